// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [2:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIXUP
  } muldiv_state_t;

  localparam int    MULDIV_ITERS = 32;
  localparam size_t DIV0_LO      = 32'hFFFF_FFFF;

  function automatic size_t abs32(input size_t v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the multiply/divide engine: shift-add or restoring shift-subtract.
module muldiv_step
  import codes::*;
(
  input  logic [63:0] acc_i,
  input  size_t       opnd_i,
  input  logic        bit_i,
  input  logic        div_i,
  output logic [63:0] acc_o
);

  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Divide keeps {remainder, quotient} in the accumulator; the next dividend bit arrives on bit_i.
  always_comb begin
    rem_sh = {acc_i[63:32], bit_i};
    diff   = rem_sh - {1'b0, opnd_i};
    if (div_i) begin
      if (diff[32])
        acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
      else
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = (acc_i << 1) + (bit_i ? {32'b0, opnd_i} : 64'b0);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Optional: MULDIV_FAST_MULT_EN selects a single-cycle multiplier for MULT/MULTU.
//
// state    | meaning
// ST_IDLE  | waiting for issue; MTHI/MTLO write here
// ST_RUN   | 32 shift-add / shift-subtract steps
// ST_FIXUP | sign correction, HI/LO write, done pulse
module muldiv_unit
  import codes::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       start_i,
  input  muldiv_op_t op_i,
  input  size_t      rs_i,
  input  size_t      rt_i,
  output size_t      hi_o,
  output size_t      lo_o,
  output logic       busy_o,
  output logic       done_o
);

  muldiv_state_t state_q;
  muldiv_op_t    op_q;
  logic [4:0]    cnt_q;
  logic [63:0]   acc_q;
  logic [63:0]   acc_nxt;
  size_t         opnd_q;
  size_t         bits_q;
  size_t         hi_q;
  size_t         lo_q;
  logic          neg_res_q;
  logic          neg_rem_q;
  logic          busy_q;
  logic          done_q;

  logic          in_signed;
  logic          in_div;
  logic          in_mult;
  size_t         rs_abs;
  size_t         rt_abs;
  muldiv_state_t accept_state;

  logic          is_div;
  logic [63:0]   mul_raw;
  logic [63:0]   mul_res;
  size_t         quot;
  size_t         rem;
  size_t         hi_fix;
  size_t         lo_fix;

  assign in_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign in_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
  assign in_mult   = (op_i == MD_MULT) || (op_i == MD_MULTU);
  assign rs_abs    = in_signed ? abs32(rs_i) : rs_i;
  assign rt_abs    = in_signed ? abs32(rt_i) : rt_i;

`ifdef MULDIV_FAST_MULT_EN
  assign accept_state = in_mult ? ST_FIXUP : ST_RUN;
  assign mul_raw      = {32'b0, opnd_q} * {32'b0, bits_q};
`else
  assign accept_state = ST_RUN;
  assign mul_raw      = acc_q;
`endif

  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

  muldiv_step u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .bit_i  (bits_q[31]),
    .div_i  (is_div),
    .acc_o  (acc_nxt)
  );

  // Magnitudes are computed in RUN; signs are restored here. Divide by zero
  // yields an all-ones quotient and the dividend magnitude as remainder, so only
  // LO needs overriding to stay all-ones regardless of the sign flags.
  always_comb begin
    mul_res = neg_res_q ? (~mul_raw + 64'd1) : mul_raw;
    quot    = acc_q[31:0];
    rem     = acc_q[63:32];
    if (is_div) begin
      hi_fix = neg_rem_q ? (~rem + 32'd1) : rem;
      if (opnd_q == 32'd0)
        lo_fix = DIV0_LO;
      else
        lo_fix = neg_res_q ? (~quot + 32'd1) : quot;
    end else begin
      hi_fix = mul_res[63:32];
      lo_fix = mul_res[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      bits_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (op_i == MD_MTHI) begin
              hi_q <= rs_i;
            end else if (op_i == MD_MTLO) begin
              lo_q <= rs_i;
            end else if (in_mult || in_div) begin
              op_q      <= op_i;
              opnd_q    <= in_div ? rt_abs : rs_abs;
              bits_q    <= in_div ? rs_abs : rt_abs;
              neg_res_q <= in_signed & (rs_i[31] ^ rt_i[31]);
              neg_rem_q <= in_signed & in_div & rs_i[31];
              acc_q     <= 64'd0;
              cnt_q     <= 5'd0;
              busy_q    <= 1'b1;
              state_q   <= accept_state;
            end
          end
        end
        ST_RUN: begin
          acc_q  <= acc_nxt;
          bits_q <= bits_q << 1;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'(MULDIV_ITERS - 1))
            state_q <= ST_FIXUP;
        end
        ST_FIXUP: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (HI/LO, latency, MT writes, reset abort).
module tb_muldiv_unit;
  import codes::*;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  muldiv_op_t op_i;
  size_t      rs_i;
  size_t      rt_i;
  size_t      hi_o;
  size_t      lo_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  typedef struct {
    size_t hi;
    size_t lo;
    int    lat;
    time   t0;
  } exp_t;

  exp_t sb[$];

  muldiv_unit dut (
    .clk     (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_o === 1'b1) chk("done_gap", {31'b0, prev_done}, 32'd0);
    prev_done = done_o;
  end

  function automatic exp_t model(input muldiv_op_t op, input size_t a, input size_t b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.lat = 33;
    e.t0  = 0;
    case (op)
      MD_MULT: begin
        p = 64'(sa * sbv);
`ifdef MULDIV_FAST_MULT_EN
        e.lat = 1;
`endif
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_FAST_MULT_EN
        e.lat = 1;
`endif
      end
      MD_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic issue(input muldiv_op_t op, input size_t a, input size_t b,
                       input bit push, input bit nowait);
    exp_t e;
    if (!nowait) @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    rs_i    = a;
    rt_i    = b;
    e = model(op, a, b);
    @(posedge clk);
    e.t0 = $time;
    if (push) sb.push_back(e);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_o !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no done expected done within 100 cycles", tag);
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed done expected no pending result", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_hi"}, hi_o, e.hi);
    chk({tag, "_lo"}, lo_o, e.lo);
    chk({tag, "_lat"}, 32'(($time - e.t0) / 10), 32'(e.lat));
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int dcount;
    reset_i = 1'b1;
    start_i = 1'b0;
    op_i    = MD_MULT;
    rs_i    = 32'd0;
    rt_i    = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    reset_i = 1'b0;

    // MT writes are visible the cycle after and never raise busy/done
    issue(MD_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mthi_hi", hi_o, 32'h1234);
    chk("mthi_busy", {31'b0, busy_o}, 32'd0);
    chk("mthi_done", {31'b0, done_o}, 32'd0);
    issue(MD_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mtlo_lo", lo_o, 32'h5678);
    chk("mtlo_hi", hi_o, 32'h1234);
    chk("mtlo_busy", {31'b0, busy_o}, 32'd0);

    // DIVU with an ignored MULT issued mid-RUN; HI/LO hold during RUN
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("run_busy", {31'b0, busy_o}, 32'd1);
    chk("run_hold_hi", hi_o, 32'h1234);
    chk("run_hold_lo", lo_o, 32'h5678);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    wait_done("divu_ign");
    chk("divu_lo_const", lo_o, 32'd14);
    chk("divu_hi_const", hi_o, 32'd2);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    wait_done("mult");
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_o, 32'hFFFF_FFFE);
    // back-to-back: drive in the done cycle so the accept lands on the next edge
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
    wait_done("multu_b2b");
    chk("multu_hi_const", hi_o, 32'h0000_0001);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done("div_neg");
    chk("div_neg_lo_const", lo_o, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done("div_ovf");
    chk("div_ovf_lo_const", lo_o, 32'h8000_0000);
    issue(MD_DIVU, 32'd5, 32'd0, 1'b1, 1'b0);
    wait_done("divu_z");
    issue(MD_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
    wait_done("div_negz");
    chk("div_negz_hi_const", hi_o, 32'hFFFF_FFFB);
    chk("div_negz_lo_const", lo_o, 32'hFFFF_FFFF);
    issue(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_done("mult_min");
    issue(MD_DIV, 32'd17, 32'hFFFF_FFFD, 1'b1, 1'b0);
    wait_done("div_negdiv");

    for (int i = 0; i < 6; i++) begin
      issue(muldiv_op_t'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, 1'b0);
      wait_done("rand");
    end

    // async reset during RUN discards the operation
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    chk("abort_busy", {31'b0, busy_o}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_i = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    issue(MD_MULTU, 32'd3, 32'd4, 1'b1, 1'b0);
    wait_done("post_rst");
    chk("post_rst_lo_const", lo_o, 32'd12);
    chk("post_rst_hi_const", hi_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
